// File: rtl/zap_wb_mem_slave_if.sv
// zap_wb_mem_slave_if
// Wishbone B3 bus bundle between a master and zap_wb_mem_slave.
//   i_wb_cyc  bus cycle valid          i_wb_stb  strobe
//   i_wb_wen  1 = write, 0 = read      i_wb_sel  byte-lane enables
//   i_wb_dat  write data               i_wb_adr  byte address
//   i_wb_cti  cycle type (000 classic, 010 incrementing, 111 end of burst)
//   o_wb_dat  registered read data     o_wb_ack  registered acknowledge
// Signal names keep the slave's point of view so that the memory sees the
// same names it always had as discrete ports.
interface zap_wb_mem_slave_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_wen;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_dat;
  logic [31:0] i_wb_adr;
  logic [2:0]  i_wb_cti;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_dat, i_wb_adr, i_wb_cti,
    input  o_wb_dat, o_wb_ack
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_dat, i_wb_adr, i_wb_cti,
    output o_wb_dat, o_wb_ack
  );
endinterface

// File: rtl/zap_wb_mem_slave.sv
// zap_wb_mem_slave
// Burst-capable Wishbone B3 memory responder. Word-organised storage with
// byte-lane writes and a fixed number of wait states before the first ack
// of every transaction. Incrementing bursts run at one beat per cycle.
// Parameters:
//   DEPTH        memory size in 32-bit words (power of two, >= 2)
//   WAIT_STATES  idle cycles before the first ack (0..15)
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   wb       Wishbone slave modport (see zap_wb_mem_slave_if)
module zap_wb_mem_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  zap_wb_mem_slave_if.slave  wb
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state;
  state_t          state_n;
  logic [3:0]      cnt;
  logic [3:0]      cnt_n;
  logic            req;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   rd_idx;
  logic            rd_load;
  logic            wr_en;
  logic [31:0]     mem [DEPTH];

  // Address bits above the memory size alias; the byte offset is covered
  // by the lane selects.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb.i_wb_adr[31:AW+2], wb.i_wb_adr[1:0]};

  assign req         = wb.i_wb_cyc & wb.i_wb_stb;
  assign idx         = wb.i_wb_adr[AW+1:2];
  assign wb.o_wb_ack = (state == ACK);

  // Next-state logic. Read data is always fetched one cycle ahead of the
  // ack it belongs to: on entry to ACK from the live address, and while a
  // burst continues from the predicted next word, so beats stay back to back.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_load = 1'b0;
    rd_idx  = idx;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_n = ACK;
            rd_load = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
        end else if (cnt == 4'd0) begin
          state_n = ACK;
          rd_load = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ACK: begin
        wr_en = req & wb.i_wb_wen;
        if (req && wb.i_wb_cti == 3'b010) begin
          rd_load = 1'b1;
          rd_idx  = idx + AW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, wait counter and registered read data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wb.o_wb_dat <= 32'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (rd_load) begin
        wb.o_wb_dat <= mem[rd_idx];
      end
    end
  end

  // Byte-lane write at the closing edge of an ack cycle. Contents are never
  // reset, but a reset at that edge cancels the write.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.i_wb_sel[b]) begin
          mem[idx][8*b +: 8] <= wb.i_wb_dat[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_zap_wb_mem_slave.sv
// tb_zap_wb_mem_slave
// Scoreboard bench for zap_wb_mem_slave. Three instances cover the
// configurations of interest: dut0 (DEPTH 1024, W 0), dut1 (DEPTH 8, W 2)
// and dut2 (DEPTH 1024, W 3). Only the selected instance sees cyc high.
// Each transaction pushes cycle-stamped expectations; a negedge monitor
// pops and compares them, and flags any ack nobody expected.
module tb_zap_wb_mem_slave;

  typedef struct {
    int          cycle;
    logic        ack;
    logic [31:0] dat;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc, m_stb, m_wen;
  logic [3:0]  m_sel;
  logic [31:0] m_dat, m_adr;
  logic [2:0]  m_cti;
  int          active = 0;
  int          cyc_no = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] bexp[$];

  zap_wb_mem_slave_if bus0();
  zap_wb_mem_slave_if bus1();
  zap_wb_mem_slave_if bus2();

  assign bus0.i_wb_cyc = m_cyc && (active == 0);
  assign bus1.i_wb_cyc = m_cyc && (active == 1);
  assign bus2.i_wb_cyc = m_cyc && (active == 2);
  assign bus0.i_wb_stb = m_stb;  assign bus1.i_wb_stb = m_stb;  assign bus2.i_wb_stb = m_stb;
  assign bus0.i_wb_wen = m_wen;  assign bus1.i_wb_wen = m_wen;  assign bus2.i_wb_wen = m_wen;
  assign bus0.i_wb_sel = m_sel;  assign bus1.i_wb_sel = m_sel;  assign bus2.i_wb_sel = m_sel;
  assign bus0.i_wb_dat = m_dat;  assign bus1.i_wb_dat = m_dat;  assign bus2.i_wb_dat = m_dat;
  assign bus0.i_wb_adr = m_adr;  assign bus1.i_wb_adr = m_adr;  assign bus2.i_wb_adr = m_adr;
  assign bus0.i_wb_cti = m_cti;  assign bus1.i_wb_cti = m_cti;  assign bus2.i_wb_cti = m_cti;

  zap_wb_mem_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (.i_clk(clk), .i_reset(rst), .wb(bus0));
  zap_wb_mem_slave #(.DEPTH(8),    .WAIT_STATES(2)) dut1 (.i_clk(clk), .i_reset(rst), .wb(bus1));
  zap_wb_mem_slave #(.DEPTH(1024), .WAIT_STATES(3)) dut2 (.i_clk(clk), .i_reset(rst), .wb(bus2));

  always #5 clk = ~clk;

  // Cycle numbering: a cycle starts at a rising edge.
  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic push_exp(input int d, input int cycle, input logic ack,
                          input logic [31:0] dat, input bit chk);
    exp_t e;
    e.cycle = cycle;
    e.ack   = ack;
    e.dat   = dat;
    e.chk   = chk;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic bit front_due(input int d, output exp_t e);
    front_due = 1'b0;
    e = '{cycle: 0, ack: 1'b0, dat: 32'h0, chk: 1'b0};
    case (d)
      0: if (q0.size() != 0 && q0[0].cycle <= cyc_no) begin e = q0.pop_front(); front_due = 1'b1; end
      1: if (q1.size() != 0 && q1[0].cycle <= cyc_no) begin e = q1.pop_front(); front_due = 1'b1; end
      default: if (q2.size() != 0 && q2[0].cycle <= cyc_no) begin e = q2.pop_front(); front_due = 1'b1; end
    endcase
  endfunction

  task automatic check_output(input int d, input logic ack, input logic [31:0] dat);
    exp_t e;
    bit   seen = 1'b0;
    while (front_due(d, e)) begin
      seen = 1'b1;
      n_checks++;
      if (e.cycle != cyc_no) begin
        n_fail++;
        $display("[TB] FAIL dut%0d stale_expectation: checked at cycle %0d, required cycle %0d",
                 d, cyc_no, e.cycle);
      end else if (ack !== e.ack || (e.chk && dat !== e.dat)) begin
        n_fail++;
        $display("[TB] FAIL dut%0d %s cycle %0d: got ack=%b dat=%h, required ack=%b dat=%h%s",
                 d, e.ack ? "ack_beat" : "no_ack", cyc_no, ack, dat, e.ack, e.dat,
                 e.chk ? "" : " (dat ignored)");
      end
    end
    if (!seen && ack === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL dut%0d unexpected_ack cycle %0d: got ack=1 dat=%h, required ack=0",
               d, cyc_no, dat);
    end
  endtask

  always @(negedge clk) begin
    check_output(0, bus0.o_wb_ack, bus0.o_wb_dat);
    check_output(1, bus1.o_wb_ack, bus1.o_wb_dat);
    check_output(2, bus2.o_wb_ack, bus2.o_wb_dat);
  end

  task automatic apply_stimulus(input logic cyc, input logic stb, input logic wen,
                                input logic [3:0] sel, input logic [31:0] dat,
                                input logic [31:0] adr, input logic [2:0] cti);
    m_cyc = cyc;  m_stb = stb;  m_wen = wen;
    m_sel = sel;  m_dat = dat;  m_adr = adr;  m_cti = cti;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000);
  endtask

  // Single transfer: request held through the ack cycle, dropped after.
  task automatic classic(input int d, input int w, input logic wen, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [31:0] adr, input logic [2:0] cti,
                         input logic [31:0] exp_dat, input bit chk);
    int t;
    t = cyc_no;
    active = d;
    push_exp(d, t + 1 + w, 1'b1, exp_dat, chk);
    push_exp(d, t + 2 + w, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i <= w + 1; i++) apply_stimulus(1'b1, 1'b1, wen, sel, dat, adr, cti);
    idle_cycle();
  endtask

  // Incrementing read burst using bexp as expected beat data. A non-negative
  // rst_beat raises reset during that beat's ack cycle and ends the burst.
  task automatic burst(input int d, input int w, input logic [31:0] base, input int rst_beat);
    int t;
    int n;
    int last;
    t = cyc_no;
    n = bexp.size();
    active = d;
    last = (rst_beat >= 0) ? rst_beat : n - 1;
    for (int i = 0; i <= last; i++) push_exp(d, t + 1 + w + i, 1'b1, bexp[i], 1'b1);
    if (rst_beat >= 0) push_exp(d, t + 2 + w + last, 1'b0, 32'h0, 1'b1);
    else               push_exp(d, t + 1 + w + n, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i <= w; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, base, 3'b010);
    for (int i = 0; i <= last; i++) begin
      if (i == rst_beat) rst = 1'b1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, base + 32'(4 * i),
                     (i == n - 1) ? 3'b111 : 3'b010);
    end
    rst = 1'b0;
    idle_cycle();
  endtask

  initial begin
    int t;
    rst = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b0; m_wen = 1'b0;
    m_sel = 4'h0; m_dat = 32'h0; m_adr = 32'h0; m_cti = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) push_exp(d, cyc_no, 1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    idle_cycle();

    // dut0, W=0: classic read/write and byte lanes
    classic(0, 0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h10, 3'b000, 32'h0, 1'b0);
    classic(0, 0, 1'b0, 4'hF, 32'h0, 32'h10, 3'b000, 32'hDEADBEEF, 1'b1);
    classic(0, 0, 1'b1, 4'hF, 32'h11223344, 32'h8, 3'b000, 32'h0, 1'b0);
    classic(0, 0, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h8, 3'b000, 32'h0, 1'b0);
    classic(0, 0, 1'b0, 4'b0001, 32'h0, 32'h8, 3'b000, 32'h11BB33DD, 1'b1);
    // Reserved cti code behaves as classic: single ack
    classic(0, 0, 1'b0, 4'hF, 32'h0, 32'h10, 3'b011, 32'hDEADBEEF, 1'b1);

    // dut0: reset during the second ack of a 4-beat burst
    for (int i = 0; i < 4; i++)
      classic(0, 0, 1'b1, 4'hF, 32'h10000010 + 32'(i), 32'h40 + 32'(4 * i), 3'b000, 32'h0, 1'b0);
    bexp = '{};
    for (int i = 0; i < 4; i++) bexp.push_back(32'h10000010 + 32'(i));
    burst(0, 0, 32'h40, 1);
    classic(0, 0, 1'b0, 4'hF, 32'h0, 32'h44, 3'b000, 32'h10000011, 1'b1);

    // dut1, DEPTH=8, W=2: burst read and wrap
    for (int i = 0; i < 4; i++)
      classic(1, 2, 1'b1, 4'hF, 32'(i), 32'(4 * i), 3'b000, 32'h0, 1'b0);
    classic(1, 2, 1'b1, 4'hF, 32'h77777777, 32'h1C, 3'b000, 32'h0, 1'b0);
    bexp = '{};
    for (int i = 0; i < 4; i++) bexp.push_back(32'(i));
    burst(1, 2, 32'h0, -1);
    classic(1, 2, 1'b1, 4'hF, 32'hC0FFEE00, 32'h0, 3'b000, 32'h0, 1'b0);
    bexp = '{};
    bexp.push_back(32'h77777777);
    bexp.push_back(32'hC0FFEE00);
    burst(1, 2, 32'h1C, -1);

    // dut2, W=3: abort in WAIT, then a fresh classic read
    classic(2, 3, 1'b1, 4'hF, 32'h5555AAAA, 32'h14, 3'b000, 32'h0, 1'b0);
    t = cyc_no;
    active = 2;
    for (int k = 1; k <= 7; k++) push_exp(2, t + k, 1'b0, 32'h0, 1'b0);
    push_exp(2, t + 8, 1'b1, 32'h5555AAAA, 1'b1);
    push_exp(2, t + 9, 1'b0, 32'h0, 1'b0);
    repeat (2) apply_stimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h14, 3'b000);
    repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h14, 3'b000);
    repeat (5) apply_stimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h14, 3'b000);
    idle_cycle();

    repeat (3) idle_cycle();
    for (int d = 0; d < 3; d++) begin
      int left;
      left = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
      n_checks++;
      if (left != 0) begin
        n_fail++;
        $display("[TB] FAIL dut%0d pending_expectations: %0d left, required 0", d, left);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
